// File: rtl/uart_apb_regbank.sv
// uart_apb_regbank: APB-style register-bank front end for the UART peripheral family.
// Decodes sel/enable/addr against REG_MAP, sequences setup/access with WAIT_CYCLES
// wait states, and issues one-hot selects, single-cycle strobes and registered read data.
// Optional build macro: UART_APB_SLVERR_EN (unmapped accesses complete with slverr=1).
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no transfer; waiting for sel=1 & enable=0 (setup phase)
// ST_SETUP | address decoded and latched; waiting for enable=1
// ST_WAIT  | access phase, counting down programmed wait states
// ST_DONE  | one-cycle completion: ready=1, strobes issued, rdata valid

module uart_apb_regbank #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter logic [NUM_REGS*ADDR_W-1:0] REG_MAP = {10'h005, 10'h004, 10'h002, 10'h000},
    parameter int WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel,
    input  logic                       enable,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ready,
    output logic                       slverr,
    output logic [NUM_REGS-1:0]        reg_sel,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic [NUM_REGS-1:0]        rd_stb,
    output logic [DATA_W-1:0]          wdata_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // WAIT_CYCLES=0 never enters ST_WAIT, so the load value is only meaningful above zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state;
    state_t              state_nxt;
    logic                write_q;
    logic [3:0]          wait_cnt;
    logic [NUM_REGS-1:0] hit_vec;
    logic [DATA_W-1:0]   rd_mux;

    // Address decode; scanning downward lets the lowest matching index win on duplicates.
    always_comb begin
        hit_vec = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (addr == REG_MAP[i*ADDR_W +: ADDR_W]) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
            end
        end
    end

    // Read-data mux driven by the latched one-hot select; a miss yields zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_sel[i]) begin
                rd_mux = rd_mux | reg_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping sel before completion abandons the transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sel && !enable) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!sel) begin
                    state_nxt = ST_IDLE;
                end else if (enable) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch decode result and direction at setup; clear the select on any return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_sel <= '0;
            write_q <= 1'b0;
        end else if (state == ST_IDLE && state_nxt == ST_SETUP) begin
            reg_sel <= hit_vec;
            write_q <= write;
        end else if (state_nxt == ST_IDLE) begin
            reg_sel <= '0;
        end
    end

    // Wait-state down-counter; ST_DONE is reached on the cycle the count is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == ST_SETUP && state_nxt == ST_WAIT) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Completion data: read data sampled on the edge entering ST_DONE and held only there;
    // write data captured for mapped writes and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= '0;
            wdata_q <= '0;
        end else begin
            rdata <= '0;
            if (state_nxt == ST_DONE) begin
                if (!write_q) begin
                    rdata <= rd_mux;
                end else if (|reg_sel) begin
                    wdata_q <= wdata;
                end
            end
        end
    end

    // Handshake and strobes exist only in ST_DONE, so each lasts exactly one cycle.
    always_comb begin
        ready  = 1'b0;
        wr_stb = '0;
        rd_stb = '0;
        if (state == ST_DONE) begin
            ready = 1'b1;
            if (write_q) begin
                wr_stb = reg_sel;
            end else begin
                rd_stb = reg_sel;
            end
        end
    end

`ifdef UART_APB_SLVERR_EN
    // Unmapped access: completes with an error response.
    assign slverr = (state == ST_DONE) && (reg_sel == '0);
`else
    // Unmapped access completes silently.
    assign slverr = 1'b0;
`endif

endmodule

// File: doc/uart_apb_regbank.md
Name: uart_apb_regbank

Overview:
Parametrised APB-style register-bank front end for the UART peripheral family; successor to the fixed 4-register combinational pointer decoder. It decodes sel/enable/addr against a configurable register map, sequences setup/access phases with programmable wait states, and issues one-hot register selects, single-cycle write/read strobes and a registered read-data return. It sits between the bus interconnect and the UART data, control, bauddiv and encode registers.

Parameters:
NUM_REGS, 4, number of mapped registers (1..16)
DATA_W, 32, bus data width
ADDR_W, 10, word-address width (addr bits [ADDR_W+1:2])
REG_MAP, {10'h005,10'h004,10'h002,10'h000}, NUM_REGS*ADDR_W packed word addresses; entry i in bits [i*ADDR_W +: ADDR_W] (byte 0x00,0x08,0x10,0x14)
WAIT_CYCLES, 0, extra access-phase cycles before ready (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sel  in  1  peripheral select
enable  in  1  access-phase qualifier
write  in  1  1=write, 0=read; sampled in setup
addr  in  ADDR_W  word address, bus bits [ADDR_W+1:2]
wdata  in  DATA_W  write data
reg_rdata  in  NUM_REGS*DATA_W  read values from register owners, reg i in [i*DATA_W +: DATA_W]
rdata  out  DATA_W  registered read data, valid while ready=1
ready  out  1  transfer-complete handshake
slverr  out  1  error response, valid while ready=1
reg_sel  out  NUM_REGS  one-hot select of decoded register, held setup through completion
wr_stb  out  NUM_REGS  one-cycle write strobe per register
rd_stb  out  NUM_REGS  one-cycle read strobe per register (for pop-on-read data regs)
wdata_q  out  DATA_W  wdata captured at completion, valid with wr_stb

Behaviour:
- Reset (rst=1 at clk edge, wins over all inputs, mid-transfer included): state IDLE; rdata=0, ready=0, slverr=0, reg_sel=0, wr_stb=0, rd_stb=0, wdata_q=0. Any in-flight transfer is abandoned and no strobe is issued.
- States: IDLE, SETUP, WAIT, DONE.
- IDLE: sel=1 & enable=0 -> SETUP; latch addr, write; compute hit vector (addr==REG_MAP[i]). Hit -> reg_sel=one-hot index. Duplicate map entries resolve to the lowest index. sel=1 & enable=1 seen in IDLE (protocol violation) -> ignored, stay IDLE.
- SETUP: enable=1 & sel=1 -> WAIT if WAIT_CYCLES>0 (load counter=WAIT_CYCLES-1), else DONE. sel=0 -> IDLE, reg_sel cleared, no strobe.
- WAIT: counter decrements each cycle; at 0 -> DONE. sel=0 at any point -> IDLE (abort), no strobe.
- DONE (1 cycle): ready=1. Write hit: wr_stb[idx]=1, wdata_q=wdata. Read hit: rd_stb[idx]=1, rdata=reg_rdata slice idx (sampled on the edge entering DONE). Miss: no strobe, rdata=0. Next cycle -> IDLE, ready/strobes=0, reg_sel=0.
- Latency from enable rise to ready: WAIT_CYCLES+1 cycles. Back-to-back: new setup accepted the cycle after DONE.
- ready is 0 whenever state≠DONE (no idle-high ready).
- addr/write changes after setup are ignored. Only the latched values are used.

Optional Feature:
UART_APB_SLVERR_EN: when defined, an unmapped access completes with slverr=1 in DONE and rdata=0. When undefined, slverr is tied 0 and unmapped accesses complete silently (writes dropped, reads return 0).

Test Plan:
- Reset mid-WAIT (WAIT_CYCLES=3, write to 0x008, rst on 2nd wait cycle) -> all outputs 0 next edge, wr_stb never pulses.
- Write 0x10 to byte 0x010, WAIT_CYCLES=0 -> ready and wr_stb=4'b0100 one cycle after enable rise, wdata_q=0x10.
- Read byte 0x014 with reg_rdata slice3=0xA5, WAIT_CYCLES=2 -> ready 3 cycles after enable, rdata=0xA5, rd_stb=4'b1000 for one cycle.
- Read unmapped byte 0x004 with UART_APB_SLVERR_EN -> ready=1, slverr=1, rdata=0, no strobes. Without the macro -> slverr=0.
- sel dropped during WAIT (WAIT_CYCLES=4) -> returns IDLE, no ready, no strobe, reg_sel=0.
- Back-to-back writes to 0x000 then 0x008 -> wr_stb=0001 then 0010, each exactly one cycle, ready never high two consecutive cycles.
